prog_seq_gen: RTL

Programmable serial sequence generator: captures a WIDTH-bit pattern and a repeat count on a start pulse, then shifts the pattern out MSB-first one bit per accepted beat, repeating it back-to-back the requested number of times. It is the transmit side for the programmable sequence detector. It is used to stimulate that detector, or any serial pattern checker, from a host-loaded pattern. Output is a valid/ready bit stream, so a downstream consumer may stall it.

---
 rtl/prog_seq_gen_if.sv | 25 ++
 rtl/prog_seq_gen.sv | 75 +++++++
 2 files changed

// File: rtl/prog_seq_gen_if.sv
// Bundle of the command (start/init/reps) and serial valid/ready stream signals for prog_seq_gen.
// The master side issues jobs and consumes the bit stream. The slave side is the generator.
interface prog_seq_gen_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] init;
  logic [CNT_W-1:0] reps;
  logic             ready;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;

  modport master (
    output start, init, reps, ready,
    input  dout, dvalid, busy, done
  );

  modport slave (
    input  start, init, reps, ready,
    output dout, dvalid, busy, done
  );
endinterface

// File: rtl/prog_seq_gen.sv
// Programmable serial sequence generator: shifts a captured WIDTH-bit pattern out MSB-first,
// repeating it back-to-back reps times, on a valid/ready bit stream.
module prog_seq_gen #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  prog_seq_gen_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rep_left;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pat      <= '0;
      shreg    <= '0;
      idx      <= '0;
      rep_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pat      <= bus.init;
            shreg    <= bus.init;
            rep_left <= bus.reps;
            idx      <= IDX_TOP;
            state    <= (bus.reps != '0) ? SEND : DONE;
          end
        end
        SEND: begin
          if (bus.ready) begin
            if (idx != '0) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
              idx   <= idx - IDX_W'(1);
            end else if (rep_left > CNT_W'(1)) begin
              // Reload in the same beat so repetitions run with no gap cycle.
              shreg    <= pat;
              idx      <= IDX_TOP;
              rep_left <= rep_left - CNT_W'(1);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stream handshake: a bit transfers on every rising edge where dvalid && ready; dout and
  // dvalid depend only on registered state, so ready never reaches them combinationally.
  assign bus.dvalid = (state == SEND);
  assign bus.dout   = (state == SEND) & shreg[WIDTH-1];
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign dbg_state  = state;

endmodule
